// File: rtl/mfcc_loop_seq_if.sv
// mfcc_loop_seq_if: config, control and address-beat stream of the loop sequencer.
// MFCC_LOOP_SEQ_ABORT_EN adds the abort input.
interface mfcc_loop_seq_if #(
  parameter int IDX_WIDTH  = 6,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic [IDX_WIDTH-1:0]  inner_last;
  logic [IDX_WIDTH-1:0]  outer_last;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [IDX_WIDTH-1:0]  out_inner;
  logic [IDX_WIDTH-1:0]  out_outer;
  logic                  out_row_end;
  logic                  out_last;
  logic                  busy;
  logic                  done;
`ifdef MFCC_LOOP_SEQ_ABORT_EN
  logic                  abort;
  modport master (
    input  start, inner_last, outer_last, base_addr, stride, out_ready, abort,
    output out_valid, out_addr, out_inner, out_outer, out_row_end, out_last, busy, done
  );
  modport slave (
    output start, inner_last, outer_last, base_addr, stride, out_ready, abort,
    input  out_valid, out_addr, out_inner, out_outer, out_row_end, out_last, busy, done
  );
`else
  modport master (
    input  start, inner_last, outer_last, base_addr, stride, out_ready,
    output out_valid, out_addr, out_inner, out_outer, out_row_end, out_last, busy, done
  );
  modport slave (
    output start, inner_last, outer_last, base_addr, stride, out_ready,
    input  out_valid, out_addr, out_inner, out_outer, out_row_end, out_last, busy, done
  );
`endif
endinterface

// File: rtl/mfcc_loop_seq.sv
// mfcc_loop_seq: two-level loop sequencer emitting one buffer address per (outer, inner) pair.
// MFCC_LOOP_SEQ_ABORT_EN enables the abort input that returns RUN to IDLE.
module mfcc_loop_seq #(
  parameter int IDX_WIDTH  = 6,
  parameter int ADDR_WIDTH = 12
) (
  input logic           clk,
  input logic           rst_n,
  mfcc_loop_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  inner_q, inner_d, outer_q, outer_d, ilast_q, ilast_d, olast_q, olast_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, row_q, row_d, stride_q, stride_d;
  logic                  run, fire, abort, row_end, last;
`ifdef MFCC_LOOP_SEQ_ABORT_EN
  assign abort = bus.abort;
`else
  assign abort = 1'b0;
`endif
  assign run     = state_q == RUN;
  assign fire    = run & bus.out_ready;
  assign row_end = inner_q == ilast_q;
  assign last    = row_end & (outer_q == olast_q);
  always_comb begin
    state_d  = state_q;
    inner_d  = inner_q;
    outer_d  = outer_q;
    ilast_d  = ilast_q;
    olast_d  = olast_q;
    addr_d   = addr_q;
    row_d    = row_q;
    stride_d = stride_q;
    if (state_q == IDLE && bus.start) begin
      state_d  = RUN;
      inner_d  = '0;
      outer_d  = '0;
      ilast_d  = bus.inner_last;
      olast_d  = bus.outer_last;
      addr_d   = bus.base_addr;
      row_d    = bus.base_addr;
      stride_d = bus.stride;
    end else if (run && abort) begin
      state_d = IDLE;
    end else if (fire) begin
      if (!row_end) begin
        inner_d = inner_q + 1'b1;
        addr_d  = addr_q + 1'b1;
      end else if (!last) begin
        inner_d = '0;
        outer_d = outer_q + 1'b1;
        row_d   = row_q + stride_q;
        addr_d  = row_q + stride_q;
      end else begin
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      inner_q  <= '0;
      outer_q  <= '0;
      ilast_q  <= '0;
      olast_q  <= '0;
      addr_q   <= '0;
      row_q    <= '0;
      stride_q <= '0;
    end else begin
      state_q  <= state_d;
      inner_q  <= inner_d;
      outer_q  <= outer_d;
      ilast_q  <= ilast_d;
      olast_q  <= olast_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      stride_q <= stride_d;
    end
  end
  // Flags are qualified by RUN so idle registers never raise them.
  assign bus.out_valid   = run;
  assign bus.busy        = run;
  assign bus.done        = state_q == DONE;
  assign bus.out_addr    = addr_q;
  assign bus.out_inner   = inner_q;
  assign bus.out_outer   = outer_q;
  assign bus.out_row_end = run & row_end;
  assign bus.out_last    = run & last;
endmodule

// File: tb/tb_mfcc_loop_seq.sv
// tb_mfcc_loop_seq: directed and randomized checks of mfcc_loop_seq against a nested-loop address model.
module tb_mfcc_loop_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  mfcc_loop_seq_if #(.IDX_WIDTH(6), .ADDR_WIDTH(12)) bus ();
  mfcc_loop_seq #(.IDX_WIDTH(6), .ADDR_WIDTH(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    int addr;
    int inner;
    int outer;
    int row_end;
    int last;
  } beat_t;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
    chk({tag, "_flags"}, {30'd0, bus.out_row_end, bus.out_last}, 0);
  endtask
  task automatic scramble_cfg();
    bus.inner_last = 6'($urandom);
    bus.outer_last = 6'($urandom);
    bus.base_addr  = 12'($urandom);
    bus.stride     = 12'($urandom);
  endtask
  // Reference: every (outer, inner) pair in row-major order, address by plain arithmetic.
  task automatic build(input int il, input int ol, input int base, input int stride, output beat_t q[$]);
    q = {};
    for (int o = 0; o <= ol; o++)
      for (int i = 0; i <= il; i++)
        q.push_back('{(base + o * stride + i) % 4096, i, o, int'(i == il), int'(i == il && o == ol)});
  endtask
  task automatic launch(input int il, input int ol, input int base, input int stride);
    @(negedge clk);
    bus.inner_last = 6'(il);
    bus.outer_last = 6'(ol);
    bus.base_addr  = 12'(base);
    bus.stride     = 12'(stride);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble_cfg();
  endtask
  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random ready; 3: ready high with a start pulse mid-run
  task automatic run_seq(input int il, input int ol, input int base, input int stride, input int mode);
    beat_t q[$];
    beat_t e;
    int    cyc = 0;
    logic  stalled = 1'b0;
    logic [31:0] prev = '0;
    logic [31:0] cur;
    build(il, ol, base, stride, q);
    launch(il, ol, base, stride);
    while (q.size() > 0 && cyc < 2000) begin
      bus.out_ready = mode == 1 ? (cyc % 3 == 0) : mode == 2 ? 1'($urandom) : 1'b1;
      bus.start = mode == 3 && cyc == 2;
      cur = {5'd0, bus.out_addr, bus.out_inner, bus.out_outer, bus.out_row_end, bus.out_last, bus.out_valid};
      if (stalled) chk("stall_hold", cur, prev);
      chk("run_valid_busy_done", {29'd0, bus.out_valid, bus.busy, bus.done}, 32'b110);
      if (bus.out_ready) begin
        e = q.pop_front();
        chk("beat_addr", {20'd0, bus.out_addr}, e.addr);
        chk("beat_idx", {20'd0, bus.out_outer, bus.out_inner}, e.outer * 64 + e.inner);
        chk("beat_flags", {30'd0, bus.out_row_end, bus.out_last}, e.row_end * 2 + e.last);
      end
      stalled = !bus.out_ready;
      prev = cur;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("seq_timeout", {31'd0, cyc >= 2000}, 0);
    chk("done_pulse", {31'd0, bus.done}, 1);
    chk_idle("after_last");
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 0);
    chk_idle("back_idle");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MFCC_LOOP_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    scramble_cfg();
    #1;
    chk("reset_all", {bus.out_addr, bus.out_inner, bus.out_outer, bus.out_valid, bus.out_row_end,
                      bus.out_last, bus.busy, bus.done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    run_seq(3, 1, 'h100, 'h10, 0);
    run_seq(0, 0, 'h7, 'h0, 0);
    run_seq(3, 1, 'h100, 'h10, 1);
    run_seq(3, 0, 'hFFE, 'h1, 0);
    run_seq(2, 2, 'hF80, 'h7F0, 3);
    // Reset while beat 3 of a sequence is presented.
    launch(3, 1, 'h100, 'h10);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_addr", {20'd0, bus.out_addr}, 'h102);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_all", {bus.out_addr, bus.out_inner, bus.out_outer, bus.out_valid,
                               bus.out_row_end, bus.out_last, bus.busy, bus.done}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", {31'd0, bus.done}, 0);
    end
    rst_n = 1'b1;
    run_seq(3, 1, 'h100, 'h10, 0);
`ifdef MFCC_LOOP_SEQ_ABORT_EN
    launch(3, 1, 'h100, 'h10);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.abort = 1'b1;
    chk("abort_beat2", {20'd0, bus.out_addr}, 'h101);
    @(negedge clk);
    bus.abort = 1'b0;
    chk_idle("abort_drop");
    chk("abort_no_done", {31'd0, bus.done}, 0);
    @(negedge clk);
    chk("abort_no_done_later", {31'd0, bus.done}, 0);
    run_seq(3, 1, 'h100, 'h10, 0);
`endif
    for (int k = 0; k < 6; k++)
      run_seq($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 4095), $urandom_range(0, 4095), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
